// File: rtl/video_timing_driver.sv
// Raster timing generator: HSYNC/VSYNC/DE plus a one-cycle-early pixel request
// (xpos/ypos) to the downstream stage, whose registered pixel_data is gated onto video_rgb.
module video_timing_driver #(
  parameter int   H_SYNC  = 40,
  parameter int   H_BACK  = 220,
  parameter int   H_DISP  = 1280,
  parameter int   H_FRONT = 110,
  parameter int   V_SYNC  = 5,
  parameter int   V_BACK  = 20,
  parameter int   V_DISP  = 720,
  parameter int   V_FRONT = 5,
  parameter logic HS_POL  = 1'b1,
  parameter logic VS_POL  = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] pixel_data,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        frame_start
);

  localparam logic [11:0] H_LAST  = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [11:0] V_LAST  = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [11:0] H_SYNC_W = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_W = 12'(V_SYNC);
  localparam logic [11:0] HA_W    = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] HE_W    = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] HR_S    = 12'(H_SYNC + H_BACK - 1);
  localparam logic [11:0] HR_E    = 12'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [11:0] VA_W    = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] VE_W    = 12'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] HR_S11  = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] VA_11   = 11'(V_SYNC + V_BACK);

  logic [11:0] cnt_h_q, cnt_h_d;
  logic [11:0] cnt_v_q, cnt_v_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic        req_q, req_d;
  logic        fs_q, fs_d;
  logic [10:0] xpos_q, xpos_d;
  logic [10:0] ypos_q, ypos_d;
  logic        v_act;

  // Outputs are decoded from the next counter value so every output is a clean flop.
  always_comb begin
    cnt_h_d = (cnt_h_q == H_LAST) ? 12'd0 : cnt_h_q + 12'd1;
    cnt_v_d = cnt_v_q;
    if (cnt_h_q == H_LAST) begin
      cnt_v_d = (cnt_v_q == V_LAST) ? 12'd0 : cnt_v_q + 12'd1;
    end

    v_act  = (cnt_v_d >= VA_W) && (cnt_v_d < VE_W);
    hs_d   = (cnt_h_d < H_SYNC_W) ? HS_POL : ~HS_POL;
    vs_d   = (cnt_v_d < V_SYNC_W) ? VS_POL : ~VS_POL;
    de_d   = v_act && (cnt_h_d >= HA_W) && (cnt_h_d < HE_W);
    req_d  = v_act && (cnt_h_d >= HR_S) && (cnt_h_d < HR_E);
    fs_d   = (cnt_h_d == 12'd0) && (cnt_v_d == 12'd0);
    xpos_d = req_d ? (cnt_h_d[10:0] - HR_S11) : 11'd0;
    ypos_d = req_d ? (cnt_v_d[10:0] - VA_11) : 11'd0;
  end

  // Reset parks the counters on the last raster position so release starts at the origin.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q <= H_LAST;
      cnt_v_q <= V_LAST;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      req_q   <= 1'b0;
      fs_q    <= 1'b0;
      xpos_q  <= 11'd0;
      ypos_q  <= 11'd0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      req_q   <= req_d;
      fs_q    <= fs_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
    end
  end

  assign video_hs    = hs_q;
  assign video_vs    = vs_q;
  assign video_de    = de_q;
  assign data_req    = req_q;
  assign frame_start = fs_q;
  assign pixel_xpos  = xpos_q;
  assign pixel_ypos  = ypos_q;
  assign video_rgb   = pixel_data & {24{de_q}};

endmodule

// File: tb/tb_video_timing_driver.sv
// Self-checking bench for video_timing_driver using a small raster (H 2/3/8/2, V 1/2/4/1)
// and a position-from-cycle-count reference model.
module tb_video_timing_driver;
  localparam int HSY = 2, HBP = 3, HDI = 8, HFP = 2;
  localparam int VSY = 1, VBP = 2, VDI = 4, VFP = 1;
  localparam int HT = HSY + HBP + HDI + HFP;
  localparam int VT = VSY + VBP + VDI + VFP;
  localparam int HA = HSY + HBP;
  localparam int VA = VSY + VBP;
  localparam int FRAME = HT * VT;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n;
  logic [23:0] pixel_data;
  logic        video_hs, video_vs, video_de, data_req, frame_start;
  logic [23:0] video_rgb;
  logic [10:0] pixel_xpos, pixel_ypos;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;
  int mode = 0;
  int de_seen = 0;
  int fs_seen = 0;
  int cur_h = 0;
  int cur_v = 0;

  video_timing_driver #(
    .H_SYNC(HSY), .H_BACK(HBP), .H_DISP(HDI), .H_FRONT(HFP),
    .V_SYNC(VSY), .V_BACK(VBP), .V_DISP(VDI), .V_FRONT(VFP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .pixel_clk(pixel_clk),
    .sys_rst_n(sys_rst_n),
    .pixel_data(pixel_data),
    .video_hs(video_hs),
    .video_vs(video_vs),
    .video_de(video_de),
    .video_rgb(video_rgb),
    .data_req(data_req),
    .pixel_xpos(pixel_xpos),
    .pixel_ypos(pixel_ypos),
    .frame_start(frame_start)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hs"}, {31'd0, video_hs}, 32'd0);
    chk({tag, "_vs"}, {31'd0, video_vs}, 32'd0);
    chk({tag, "_de"}, {31'd0, video_de}, 32'd0);
    chk({tag, "_req"}, {31'd0, data_req}, 32'd0);
    chk({tag, "_fs"}, {31'd0, frame_start}, 32'd0);
    chk({tag, "_x"}, {21'd0, pixel_xpos}, 32'd0);
    chk({tag, "_y"}, {21'd0, pixel_ypos}, 32'd0);
    chk({tag, "_rgb"}, {8'd0, video_rgb}, 32'd0);
  endtask

  // One clock: acts as video_display (registers the request), then checks every output
  // against the raster position derived from the number of edges since reset release.
  task automatic cyc();
    logic [10:0] px, py, e_x, e_y;
    logic        e_hs, e_vs, e_de, e_req, e_fs, vact;
    logic [23:0] e_rgb;
    int p, h, v;
    px = pixel_xpos;
    py = pixel_ypos;
    @(posedge pixel_clk);
    k++;
    #1;
    case (mode)
      0: pixel_data = {2'b00, py, px};
      1: pixel_data = 24'h123456;
      default: pixel_data = 24'($urandom);
    endcase
    #1;
    p = (k - 1) % FRAME;
    h = p % HT;
    v = p / HT;
    cur_h = h;
    cur_v = v;
    e_hs  = (h < HSY);
    e_vs  = (v < VSY);
    vact  = (v >= VA) && (v < VA + VDI);
    e_de  = vact && (h >= HA) && (h < HA + HDI);
    e_req = vact && (h >= HA - 1) && (h < HA + HDI - 1);
    e_fs  = (h == 0) && (v == 0);
    e_x   = e_req ? 11'(h - HA + 1) : 11'd0;
    e_y   = e_req ? 11'(v - VA) : 11'd0;
    if (!e_de) e_rgb = 24'd0;
    else if (mode == 0) e_rgb = {2'b00, 11'(v - VA), 11'(h - HA)};
    else e_rgb = pixel_data;
    chk("hs", {31'd0, video_hs}, {31'd0, e_hs});
    chk("vs", {31'd0, video_vs}, {31'd0, e_vs});
    chk("de", {31'd0, video_de}, {31'd0, e_de});
    chk("req", {31'd0, data_req}, {31'd0, e_req});
    chk("fs", {31'd0, frame_start}, {31'd0, e_fs});
    chk("xpos", {21'd0, pixel_xpos}, {21'd0, e_x});
    chk("ypos", {21'd0, pixel_ypos}, {21'd0, e_y});
    chk("rgb", {8'd0, video_rgb}, {8'd0, e_rgb});
    if (video_de === 1'b1) de_seen++;
    if (frame_start === 1'b1) fs_seen++;
  endtask

  initial begin
    int found;
    sys_rst_n  = 1'b0;
    pixel_data = 24'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pixel_clk);
      pixel_data = 24'($urandom);
      #1;
      if (i == 0 || i == 9) chk_reset("rst");
    end
    $display("reset hold: 10 cycles done");

    @(negedge pixel_clk);
    sys_rst_n = 1'b1;
    k = 0;
    mode = 0;
    de_seen = 0;
    fs_seen = 0;
    repeat (2 * FRAME) cyc();
    chk("de_cnt_2frames", de_seen, 2 * HDI * VDI);
    chk("fs_cnt_2frames", fs_seen, 2);
    $display("display-model phase: 2 frames, de=%0d fs=%0d", de_seen, fs_seen);

    mode = 1;
    repeat (FRAME) cyc();
    $display("constant pixel_data phase: 1 frame");

    mode = 2;
    repeat (FRAME) cyc();
    $display("random pixel_data phase: 1 frame");

    mode = 0;
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc();
      if (cur_h == 10 && cur_v == 3) begin
        found = 1;
        break;
      end
    end
    chk("mid_pos_found", found, 1);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk_reset("mid_rst_async");
    for (int i = 0; i < 5; i++) begin
      @(negedge pixel_clk);
      pixel_data = 24'($urandom);
      #1;
      chk_reset("mid_rst_hold");
    end
    sys_rst_n = 1'b1;
    k = 0;
    de_seen = 0;
    fs_seen = 0;
    repeat (FRAME) cyc();
    chk("mid_de_cnt", de_seen, HDI * VDI);
    chk("mid_fs_cnt", fs_seen, 1);
    $display("mid-frame reset phase: de=%0d fs=%0d", de_seen, fs_seen);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/video_timing_driver.md
# video_timing_driver

Video timing generator and pixel-fetch front end for the HDMI display path. Generates HSYNC/VSYNC/DE for a progressive raster (default 1280x720@60, 74.25 MHz pixel_clk). Requests pixels from the downstream pattern/graphics stage (`video_display`) one cycle early via `pixel_xpos`/`pixel_ypos`. Returns the registered `pixel_data` to the TMDS encoder as `video_rgb`, aligned with `video_de`.

## Interface
Parameters:
- H_SYNC, 40: HSYNC width, pixels
- H_BACK, 220: horizontal back porch
- H_DISP, 1280: active pixels per line
- H_FRONT, 110: horizontal front porch
- V_SYNC, 5: VSYNC width, lines
- V_BACK, 20: vertical back porch
- V_DISP, 720: active lines
- V_FRONT, 5: vertical front porch
- HS_POL, 1: HSYNC active level
- VS_POL, 1: VSYNC active level

Derived values:
- H_TOTAL = sum of the four H values (1650). V_TOTAL = sum of the four V values (750).
- HA = H_SYNC+H_BACK (260). VA = V_SYNC+V_BACK (25).

Ports (reset sys_rst_n, asynchronous, active-low; clock pixel_clk):
- pixel_clk  in  1  pixel clock
- sys_rst_n  in  1  async active-low reset
- pixel_data  in  24  RGB from the downstream stage, registered there one cycle after xpos/ypos
- video_hs  out  1  horizontal sync
- video_vs  out  1  vertical sync
- video_de  out  1  active-video enable
- video_rgb  out  24  pixel_data gated by video_de
- data_req  out  1  pixel request, leads video_de by one cycle
- pixel_xpos  out  11  requested column, 0..H_DISP-1
- pixel_ypos  out  11  requested row, 0..V_DISP-1
- frame_start  out  1  one-cycle pulse at raster origin

## Operation
Counters:
- cnt_h: 12 bits, counts 0..H_TOTAL-1 and wraps to 0.
- cnt_v: 12 bits, increments only when cnt_h==H_TOTAL-1, and wraps to 0 after V_TOTAL-1.
- Reset value is cnt_h=H_TOTAL-1, cnt_v=V_TOTAL-1. The first rising edge after reset release therefore lands on (0,0).

Output functions of the current (cnt_h, cnt_v):
- video_hs = HS_POL while cnt_h < H_SYNC, otherwise ~HS_POL.
- video_vs = VS_POL while cnt_v < V_SYNC, otherwise ~VS_POL.
- v_act is true when VA <= cnt_v < VA+V_DISP.
- video_de = v_act && HA <= cnt_h < HA+H_DISP.
- data_req = v_act && HA-1 <= cnt_h < HA+H_DISP-1.
- pixel_xpos = cnt_h-(HA-1) when data_req is high, else 0.
- pixel_ypos = cnt_v-VA when data_req is high, else 0.
- frame_start = 1 exactly when cnt_h==0 && cnt_v==0.
- video_rgb = pixel_data when video_de is high, else 24'h000000.

Implementation rules:
- All outputs except video_rgb are flops. Compute them from next-counter values so they change only on clock edges and stay glitch-free.
- video_rgb is a single AND-gate stage on pixel_data.
- Subtractions use 12-bit arithmetic, truncated to 11 bits. Any out-of-window value is forced to 0 and is never observed.

## Timing
- Reset (asserted): cnt_h=H_TOTAL-1 and cnt_v=V_TOTAL-1. video_hs=~HS_POL, video_vs=~VS_POL. video_de, data_req, frame_start, pixel_xpos, pixel_ypos are all 0. video_rgb=0.
- First edge after release: frame_start=1, video_hs and video_vs go active.
- Request latency: request (x,y) is issued at cycle t. video_display returns pixel_data at t+1. video_de is high at t+1, so video_rgb carries pixel (x,y) at t+1.
- Lines, default parameters:
  - data_req is high for cnt_h 259..1538; video_de for 260..1539.
  - The last request, x=1279, is at cnt_h=1538.
  - No request or DE occurs on blank lines (cnt_v <25 or >=745), including the HA-1 lead cycle.
- Wrap: line 749 col 1649 is followed by (0,0) with a frame_start pulse. No gap cycle and no double pulse.
- Reset mid-frame: all outputs return immediately (asynchronously) to reset values. After release, timing restarts at (0,0). No partial-line DE is emitted.
- pixel_data changes while video_de is low must never reach video_rgb.

## Test plan
- Reset: hold sys_rst_n low for 10 cycles -> video_hs=0, video_vs=0, video_de=0, video_rgb=0, and pixel_xpos, pixel_ypos, data_req, frame_start all 0. First edge after release -> frame_start=1, video_hs=1, video_vs=1.
- Horizontal timing (defaults), measured over 3 lines:
  - HSYNC period 1650 cycles, high for 40.
  - video_de high 1280 consecutive cycles starting at cnt_h=260.
  - data_req rises exactly 1 cycle before video_de and falls 1 cycle before it.
- Vertical timing: over 2 frames -> VSYNC high for 5*1650=8250 cycles; frame period 1237500 cycles; 921600 DE cycles per frame; exactly one frame_start per frame.
- Coordinates, with a model of `video_display` that registers {ypos,xpos} as pixel_data:
  - video_rgb = {y,x} on every DE cycle.
  - First pixel of a frame = (0,0); last = (1279,719).
  - xpos=0 and ypos=0 whenever data_req is low.
- Gating: force pixel_data=24'h123456 constantly -> video_rgb=24'h123456 only while video_de=1, and 0 in all blanking cycles.
- Reset mid-operation with small parameters (H:2/3/8/2, V:1/2/4/1): assert reset at line 3 col 10, release after 5 cycles -> outputs at reset values during reset. frame_start on the first edge after release. The following frame has the full count of 32 DE cycles.
